// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver plus arrow/space decoder; byteValid/frameErr in E+1, key levels and start in E+2.
// Pure receiver: no backpressure, each valid byte is consumed in the cycle it is flagged.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       leftPress,
    output logic       rightPress,
    output logic       start,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       frameErr
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic            clk_s1_q, clk_s2_q, clk_prev_q;
    logic            dat_s1_q, dat_s2_q;
    logic            edge_q, bit_q;
    state_t          state_q, state_d;
    logic [2:0]      cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [WD_W-1:0] wd_q;
    logic            timeout;
    logic            frame_ok_d, frame_bad_d;
    logic            byte_vld_q, byte_err_q;
    logic [7:0]      byte_dat_q;
    logic            ext_q, ext_d, brk_q, brk_d, space_q, space_d;
    logic            left_q, left_d, right_q, right_d, start_q, start_d;

    // Synchronizers reset to the idle-high line level so no edge is seen after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            edge_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_s1_q   <= ps2Clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2Data;
            dat_s2_q   <= dat_s1_q;
            edge_q     <= !clk_s2_q && clk_prev_q;
            bit_q      <= dat_s2_q;
        end
    end

    assign timeout = (state_q != S_IDLE) && !edge_q && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (edge_q) begin
            case (state_q)
                S_IDLE:   if (!bit_q) state_d = S_DATA;
                S_DATA:   if (cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_ok_d  = 1'b0;
        frame_bad_d = timeout;
        if (edge_q && state_q == S_STOP) begin
            if ((^{shift_q, par_q}) && bit_q) begin
                frame_ok_d = 1'b1;
            end else begin
                frame_bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            wd_q       <= '0;
            byte_vld_q <= 1'b0;
            byte_err_q <= 1'b0;
            byte_dat_q <= 8'h00;
        end else begin
            byte_vld_q <= frame_ok_d;
            byte_err_q <= frame_bad_d;
            if (frame_ok_d) byte_dat_q <= shift_q;
            if (state_q == S_IDLE || edge_q || timeout) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (edge_q) begin
                case (state_q)
                    S_IDLE: cnt_q <= 3'd0;
                    S_DATA: begin
                        shift_q <= {bit_q, shift_q[7:1]};
                        cnt_q   <= cnt_q + 3'd1;
                    end
                    S_PARITY: par_q <= bit_q;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        space_d = space_q;
        left_d  = left_q;
        right_d = right_q;
        start_d = 1'b0;
        if (byte_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q) begin
            if (byte_dat_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_dat_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q && byte_dat_q == 8'h6B) begin
                    left_d = !brk_q;
                end else if (ext_q && byte_dat_q == 8'h74) begin
                    right_d = !brk_q;
                end else if (!ext_q && byte_dat_q == 8'h29) begin
                    // A make while already held is typematic repeat and must not restart the game.
                    if (brk_q) begin
                        space_d = 1'b0;
                    end else if (!space_q) begin
                        space_d = 1'b1;
                        start_d = 1'b1;
                    end
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            space_q <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            space_q <= space_d;
            left_q  <= left_d;
            right_q <= right_d;
            start_q <= start_d;
        end
    end

    assign leftPress  = left_q;
    assign rightPress = right_q;
    assign start      = start_q;
    assign byteValid  = byte_vld_q;
    assign byteData   = byte_dat_q;
    assign frameErr   = byte_err_q;

endmodule
